reg_read_lane: RTL and testbench
================================

// Module: reg_read_lane
// PURPOSE
// - Per-lane register-read stage directly downstream of the issue-queue/reg-read pipeline register.
// - Takes one issued packet per cycle and reads both source physical registers from the
//   synchronous-read PRF. It merges writeback bypass values and hands a fully-operanded packet
//   to the execute pipe register.
// - Two internal stages, S1 (PRF read in flight) and S2 (operands held). Full valid/ready backpressure.
// PARAMETERS
// - DATA_WIDTH    64  operand/bypass data width
// - PREG_WIDTH    7   physical register tag width
// - PAYLOAD_WIDTH 96  opaque payload bits carried alongside operands (opcode, dest, imm, ...)
// - NUM_BYPASS    4   number of writeback bypass ports
// PORTS
// - clk             in   1                        clock
// - reset           in   1                        asynchronous, active-high reset
// - flush_i         in   1                        synchronous squash of all in-flight packets
// - inValid_i       in   1                        issued packet valid
// - inReady_o       out  1                        stage can accept this cycle
// - inPayload_i     in   PAYLOAD_WIDTH            opaque payload
// - inSrc1_i        in   PREG_WIDTH               source 1 tag
// - inSrc2_i        in   PREG_WIDTH               source 2 tag
// - inSrc1Vld_i     in   1                        source 1 is a register operand
// - inSrc2Vld_i     in   1                        source 2 is a register operand
// - prfAddr1_o      out  PREG_WIDTH               PRF read address, port 1
// - prfAddr2_o      out  PREG_WIDTH               PRF read address, port 2
// - prfData1_i      in   DATA_WIDTH               PRF data; returns the cycle after the address edge
// - prfData2_i      in   DATA_WIDTH               PRF data, port 2; same timing as port 1
// - bypValid_i      in   NUM_BYPASS               bypass port valid
// - bypTag_i        in   NUM_BYPASS*PREG_WIDTH    bypass tags, port k at [k*PREG_WIDTH +: PREG_WIDTH]
// - bypData_i       in   NUM_BYPASS*DATA_WIDTH    bypass data, port k at [k*DATA_WIDTH +: DATA_WIDTH]
// - exeValid_o      out  1                        output packet valid
// - exeReady_i      in   1                        execute stage accepts
// - exePayload_o    out  PAYLOAD_WIDTH            payload from S2
// - exeOpnd1_o      out  DATA_WIDTH               resolved operand 1 (0 if src1 not a register)
// - exeOpnd2_o      out  DATA_WIDTH               resolved operand 2 (0 if src2 not a register)
// BEHAVIOUR
// - Reset: s1Valid=s2Valid=0, all sticky bits 0, exeValid_o=0, exeOpnd*/exePayload_o=0, inReady_o=1.
// - s2Adv = !s2Valid | exeReady_i. s1Adv = !s1Valid | s2Adv. inReady_o = s1Adv (combinational).
// - Accept when inValid_i & inReady_o: S1 loads payload, tags and src-valid flags; s1Valid<=1.
// - PRF address: prfAddrN_o = (s1Valid & !s2Adv) ? s1SrcN : inSrcN_i. A held S1 re-reads every cycle.
// - PRF read-during-write returns OLD data. Bypass handling covers this:
//   - Sticky capture: any cycle a match exists, set stickyN/stickyDataN.
//     - At accept, matches against inSrcN_i load the sticky state fresh.
//     - While S1 holds, matches against s1SrcN set it.
//   - Sticky state clears when S1 loads a new packet, or on flush/reset.
// - S1->S2 transfer when s1Valid & s2Adv. Operand N = !srcVldN ? 0 : (current-cycle bypass
//   match on s1SrcN ? bypData : stickyN ? stickyDataN : prfDataN_i).
// - Multiple bypass ports matching one tag: lowest-index port wins.
// - Tag 0 gets no special treatment.
// - S2 holds output stable while exeValid_o & !exeReady_i. Output operands do not snoop bypass.
// - Latency: accept at cycle T -> exeValid_o at T+2 if no stall. Throughput 1 packet/cycle.
// - Simultaneous S2 drain, S1 advance and new accept in one cycle: all three occur.
// - flush_i (synchronous): s1Valid, s2Valid and sticky state <=0. inReady_o is still computed,
//   but an accept in the flush cycle is dropped. Flush dominates accept.
// - Reset mid-operation drops all packets immediately (async). No output X after reset release.
// TESTING
// - Back-to-back: 5 packets, exeReady_i=1, PRF holds reg n = 0x100+n.
//   -> exeValid_o rises at T+2, 5 consecutive cycles, operands correct, inReady_o=1 throughout.
// - Stall: exeReady_i=0 for 3 cycles with S1 and S2 full.
//   -> inReady_o=0; outputs stable; prfAddr*_o = S1 tags; drains in order after release.
// - Bypass at accept: bypass port 2 writes tag 9 = 0xDEAD in the accept cycle, PRF returns stale 0x9.
//   -> exeOpnd1_o = 0xDEAD.
// - Bypass during S1 hold: tag 5 = 0xBEEF arrives in hold cycle 2 of 3.
//   -> output 0xBEEF. If ports 0 and 3 both hit one tag -> port 0 data wins.
// - Flush with S1 and S2 valid and inValid_i=1 -> next cycle exeValid_o=0; nothing from before the flush emerges.
// - Async reset asserted mid-stall -> exeValid_o=0 before the next clk edge; all outputs 0.

Source files
------------

// File: rtl/reg_read_lane.sv
// Register-read lane: S1 holds an issued packet while the synchronous PRF read is in flight,
// S2 holds the fully resolved operands for the execute stage. Bypass writes are merged on the way.
module reg_read_lane #(
  parameter int DATA_WIDTH    = 64,
  parameter int PREG_WIDTH    = 7,
  parameter int PAYLOAD_WIDTH = 96,
  parameter int NUM_BYPASS    = 4
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             flush_i,
  input  logic                             inValid_i,
  output logic                             inReady_o,
  input  logic [PAYLOAD_WIDTH-1:0]         inPayload_i,
  input  logic [PREG_WIDTH-1:0]            inSrc1_i,
  input  logic [PREG_WIDTH-1:0]            inSrc2_i,
  input  logic                             inSrc1Vld_i,
  input  logic                             inSrc2Vld_i,
  output logic [PREG_WIDTH-1:0]            prfAddr1_o,
  output logic [PREG_WIDTH-1:0]            prfAddr2_o,
  input  logic [DATA_WIDTH-1:0]            prfData1_i,
  input  logic [DATA_WIDTH-1:0]            prfData2_i,
  input  logic [NUM_BYPASS-1:0]            bypValid_i,
  input  logic [NUM_BYPASS*PREG_WIDTH-1:0] bypTag_i,
  input  logic [NUM_BYPASS*DATA_WIDTH-1:0] bypData_i,
  output logic                             exeValid_o,
  input  logic                             exeReady_i,
  output logic [PAYLOAD_WIDTH-1:0]         exePayload_o,
  output logic [DATA_WIDTH-1:0]            exeOpnd1_o,
  output logic [DATA_WIDTH-1:0]            exeOpnd2_o
);

  // Handshake: a transfer happens on a cycle where valid and ready are both high; ready never
  // depends on valid of the same interface, and a held valid keeps its data stable.

  // Returns {hit, data}; the lowest-index matching port wins.
  function automatic logic [DATA_WIDTH:0] byp_lookup(input logic [PREG_WIDTH-1:0] tag);
    logic [DATA_WIDTH:0] r;
    r = '0;
    for (int k = NUM_BYPASS - 1; k >= 0; k--) begin
      if (bypValid_i[k] && (bypTag_i[k*PREG_WIDTH +: PREG_WIDTH] == tag))
        r = {1'b1, bypData_i[k*DATA_WIDTH +: DATA_WIDTH]};
    end
    return r;
  endfunction

  logic                     s1_valid_q, s1_valid_d;
  logic [PAYLOAD_WIDTH-1:0] s1_payload_q, s1_payload_d;
  logic [PREG_WIDTH-1:0]    s1_src1_q, s1_src1_d, s1_src2_q, s1_src2_d;
  logic                     s1_vld1_q, s1_vld1_d, s1_vld2_q, s1_vld2_d;
  logic                     sticky1_q, sticky1_d, sticky2_q, sticky2_d;
  logic [DATA_WIDTH-1:0]    sticky_data1_q, sticky_data1_d, sticky_data2_q, sticky_data2_d;
  logic                     s2_valid_q, s2_valid_d;
  logic [PAYLOAD_WIDTH-1:0] s2_payload_q, s2_payload_d;
  logic [DATA_WIDTH-1:0]    s2_opnd1_q, s2_opnd1_d, s2_opnd2_q, s2_opnd2_d;

  logic s2_adv, s1_adv, accept, s1_hold, s1_xfer;
  logic [DATA_WIDTH:0] in_hit1, in_hit2, s1_hit1, s1_hit2;
  logic [DATA_WIDTH-1:0] opnd1, opnd2;

  always_comb begin
    s2_adv    = !s2_valid_q || exeReady_i;
    s1_adv    = !s1_valid_q || s2_adv;
    inReady_o = s1_adv;
    accept    = inValid_i && s1_adv && !flush_i;
    s1_hold   = s1_valid_q && !s2_adv;
    s1_xfer   = s1_valid_q && s2_adv;

    // A held S1 keeps re-reading its own tags so fresh PRF writes are eventually seen.
    prfAddr1_o = s1_hold ? s1_src1_q : inSrc1_i;
    prfAddr2_o = s1_hold ? s1_src2_q : inSrc2_i;

    in_hit1 = byp_lookup(inSrc1_i);
    in_hit2 = byp_lookup(inSrc2_i);
    s1_hit1 = byp_lookup(s1_src1_q);
    s1_hit2 = byp_lookup(s1_src2_q);

    opnd1 = !s1_vld1_q ? '0 : s1_hit1[DATA_WIDTH] ? s1_hit1[DATA_WIDTH-1:0] :
            sticky1_q ? sticky_data1_q : prfData1_i;
    opnd2 = !s1_vld2_q ? '0 : s1_hit2[DATA_WIDTH] ? s1_hit2[DATA_WIDTH-1:0] :
            sticky2_q ? sticky_data2_q : prfData2_i;
  end

  always_comb begin
    s1_valid_d     = s1_valid_q;
    s1_payload_d   = s1_payload_q;
    s1_src1_d      = s1_src1_q;
    s1_src2_d      = s1_src2_q;
    s1_vld1_d      = s1_vld1_q;
    s1_vld2_d      = s1_vld2_q;
    sticky1_d      = sticky1_q;
    sticky2_d      = sticky2_q;
    sticky_data1_d = sticky_data1_q;
    sticky_data2_d = sticky_data2_q;

    if (accept) begin
      s1_valid_d     = 1'b1;
      s1_payload_d   = inPayload_i;
      s1_src1_d      = inSrc1_i;
      s1_src2_d      = inSrc2_i;
      s1_vld1_d      = inSrc1Vld_i;
      s1_vld2_d      = inSrc2Vld_i;
      // The PRF read issued this cycle returns pre-write data, so remember same-cycle writes.
      sticky1_d      = in_hit1[DATA_WIDTH];
      sticky2_d      = in_hit2[DATA_WIDTH];
      sticky_data1_d = in_hit1[DATA_WIDTH-1:0];
      sticky_data2_d = in_hit2[DATA_WIDTH-1:0];
    end else begin
      if (s1_xfer) s1_valid_d = 1'b0;
      if (s1_hold && s1_hit1[DATA_WIDTH]) begin
        sticky1_d      = 1'b1;
        sticky_data1_d = s1_hit1[DATA_WIDTH-1:0];
      end
      if (s1_hold && s1_hit2[DATA_WIDTH]) begin
        sticky2_d      = 1'b1;
        sticky_data2_d = s1_hit2[DATA_WIDTH-1:0];
      end
    end

    if (flush_i) begin
      s1_valid_d = 1'b0;
      sticky1_d  = 1'b0;
      sticky2_d  = 1'b0;
    end
  end

  always_comb begin
    s2_valid_d   = s1_xfer ? 1'b1 : (s2_adv ? 1'b0 : s2_valid_q);
    s2_payload_d = s1_xfer ? s1_payload_q : s2_payload_q;
    s2_opnd1_d   = s1_xfer ? opnd1 : s2_opnd1_q;
    s2_opnd2_d   = s1_xfer ? opnd2 : s2_opnd2_q;
    if (flush_i) s2_valid_d = 1'b0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_valid_q     <= 1'b0;
      s1_payload_q   <= '0;
      s1_src1_q      <= '0;
      s1_src2_q      <= '0;
      s1_vld1_q      <= 1'b0;
      s1_vld2_q      <= 1'b0;
      sticky1_q      <= 1'b0;
      sticky2_q      <= 1'b0;
      sticky_data1_q <= '0;
      sticky_data2_q <= '0;
      s2_valid_q     <= 1'b0;
      s2_payload_q   <= '0;
      s2_opnd1_q     <= '0;
      s2_opnd2_q     <= '0;
    end else begin
      s1_valid_q     <= s1_valid_d;
      s1_payload_q   <= s1_payload_d;
      s1_src1_q      <= s1_src1_d;
      s1_src2_q      <= s1_src2_d;
      s1_vld1_q      <= s1_vld1_d;
      s1_vld2_q      <= s1_vld2_d;
      sticky1_q      <= sticky1_d;
      sticky2_q      <= sticky2_d;
      sticky_data1_q <= sticky_data1_d;
      sticky_data2_q <= sticky_data2_d;
      s2_valid_q     <= s2_valid_d;
      s2_payload_q   <= s2_payload_d;
      s2_opnd1_q     <= s2_opnd1_d;
      s2_opnd2_q     <= s2_opnd2_d;
    end
  end

  assign exeValid_o   = s2_valid_q;
  assign exePayload_o = s2_payload_q;
  assign exeOpnd1_o   = s2_opnd1_q;
  assign exeOpnd2_o   = s2_opnd2_q;

endmodule

// File: tb/tb_reg_read_lane.sv
// Bench for reg_read_lane: a register-file environment plus a transaction-level model that
// predicts every packet's operands as the register values current when the packet leaves S1.
module tb_reg_read_lane;

  logic          clk = 1'b0;
  logic          reset;
  logic          flush_i;
  logic          inValid_i;
  logic          inReady_o;
  logic [95:0]   inPayload_i;
  logic [6:0]    inSrc1_i, inSrc2_i;
  logic          inSrc1Vld_i, inSrc2Vld_i;
  logic [6:0]    prfAddr1_o, prfAddr2_o;
  logic [63:0]   prfData1_i, prfData2_i;
  logic [3:0]    bypValid_i;
  logic [27:0]   bypTag_i;
  logic [255:0]  bypData_i;
  logic          exeValid_o;
  logic          exeReady_i;
  logic [95:0]   exePayload_o;
  logic [63:0]   exeOpnd1_o, exeOpnd2_o;

  reg_read_lane dut (
    .clk(clk), .reset(reset), .flush_i(flush_i),
    .inValid_i(inValid_i), .inReady_o(inReady_o), .inPayload_i(inPayload_i),
    .inSrc1_i(inSrc1_i), .inSrc2_i(inSrc2_i), .inSrc1Vld_i(inSrc1Vld_i), .inSrc2Vld_i(inSrc2Vld_i),
    .prfAddr1_o(prfAddr1_o), .prfAddr2_o(prfAddr2_o), .prfData1_i(prfData1_i), .prfData2_i(prfData2_i),
    .bypValid_i(bypValid_i), .bypTag_i(bypTag_i), .bypData_i(bypData_i),
    .exeValid_o(exeValid_o), .exeReady_i(exeReady_i), .exePayload_o(exePayload_o),
    .exeOpnd1_o(exeOpnd1_o), .exeOpnd2_o(exeOpnd2_o)
  );

  always #5 clk = ~clk;

  typedef struct { logic [95:0] pl; logic [6:0] t1, t2; logic v1, v2; } pkt_t;
  typedef struct { logic [95:0] pl; logic [63:0] o1, o2; } out_t;

  logic [63:0] arch [128];
  pkt_t s1_m[$];
  out_t s2_m[$];
  logic [95:0] obs_pl[$];
  logic [63:0] obs_o1[$], obs_o2[$];
  int acc_cyc[$], out_cyc[$];
  int cyc = 0;
  int n_checks = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Register value after this cycle's writes; port 0 has priority over higher ports.
  function automatic logic [63:0] cur_val(input logic [6:0] t);
    for (int k = 0; k < 4; k++)
      if (bypValid_i[k] && bypTag_i[k*7 +: 7] == t) return bypData_i[k*64 +: 64];
    return arch[t];
  endfunction

  task automatic idle();
    flush_i = 0; inValid_i = 0; bypValid_i = '0; exeReady_i = 1;
  endtask

  task automatic set_pkt(input logic [95:0] pl, input logic [6:0] t1, input logic [6:0] t2,
                         input logic v1, input logic v2);
    inValid_i = 1; inPayload_i = pl; inSrc1_i = t1; inSrc2_i = t2;
    inSrc1Vld_i = v1; inSrc2Vld_i = v2;
  endtask

  task automatic cycle();
    logic s2_out, s2_free, exp_ready;
    logic [6:0] a1, a2;
    logic [63:0] rd1, rd2;
    pkt_t p;
    out_t o;
    #1;
    s2_out    = (s2_m.size() != 0) && exeReady_i;
    s2_free   = (s2_m.size() == 0) || exeReady_i;
    exp_ready = (s1_m.size() == 0) || s2_free;
    chk("in_ready", inReady_o, exp_ready);
    chk("exe_valid", exeValid_o, s2_m.size() != 0);
    if (s2_m.size() != 0) begin
      chk("exe_payload", exePayload_o, s2_m[0].pl);
      chk("exe_opnd1", exeOpnd1_o, s2_m[0].o1);
      chk("exe_opnd2", exeOpnd2_o, s2_m[0].o2);
    end
    if (s1_m.size() != 0 && !s2_free) begin
      chk("prf_addr1_hold", prfAddr1_o, s1_m[0].t1);
      chk("prf_addr2_hold", prfAddr2_o, s1_m[0].t2);
    end
    if (exeValid_o && exeReady_i) begin
      obs_pl.push_back(exePayload_o); obs_o1.push_back(exeOpnd1_o); obs_o2.push_back(exeOpnd2_o);
      out_cyc.push_back(cyc);
    end
    if (inValid_i && inReady_o && !flush_i) acc_cyc.push_back(cyc);
    a1 = prfAddr1_o; a2 = prfAddr2_o;
    if (flush_i) begin
      s1_m.delete(); s2_m.delete();
    end else begin
      if (s2_out) void'(s2_m.pop_front());
      if (s1_m.size() != 0 && s2_free) begin
        p = s1_m.pop_front();
        o.pl = p.pl;
        o.o1 = p.v1 ? cur_val(p.t1) : 64'h0;
        o.o2 = p.v2 ? cur_val(p.t2) : 64'h0;
        s2_m.push_back(o);
      end
      if (inValid_i && exp_ready) begin
        p.pl = inPayload_i; p.t1 = inSrc1_i; p.t2 = inSrc2_i; p.v1 = inSrc1Vld_i; p.v2 = inSrc2Vld_i;
        s1_m.push_back(p);
      end
    end
    @(posedge clk);
    // Synchronous PRF: the read sees the contents from before this edge's writes.
    rd1 = arch[a1]; rd2 = arch[a2];
    for (int k = 3; k >= 0; k--)
      if (bypValid_i[k]) arch[bypTag_i[k*7 +: 7]] = bypData_i[k*64 +: 64];
    cyc++;
    #1;
    prfData1_i = rd1; prfData2_i = rd2;
    @(negedge clk);
  endtask

  task automatic clear_obs();
    obs_pl.delete(); obs_o1.delete(); obs_o2.delete(); acc_cyc.delete(); out_cyc.delete();
  endtask

  initial begin
    for (int n = 0; n < 128; n++) arch[n] = 64'h100 + 64'(n);
    reset = 1; flush_i = 0; inValid_i = 0; inPayload_i = '0; inSrc1_i = '0; inSrc2_i = '0;
    inSrc1Vld_i = 0; inSrc2Vld_i = 0; prfData1_i = '0; prfData2_i = '0;
    bypValid_i = '0; bypTag_i = '0; bypData_i = '0; exeReady_i = 1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_exe_valid", exeValid_o, 1'b0);
    chk("rst_in_ready", inReady_o, 1'b1);
    chk("rst_payload", exePayload_o, 96'h0);
    chk("rst_opnd1", exeOpnd1_o, 64'h0);
    chk("rst_opnd2", exeOpnd2_o, 64'h0);
    @(negedge clk);
    reset = 0;

    // Back-to-back, no stall.
    clear_obs();
    for (int i = 0; i < 5; i++) begin
      set_pkt(96'(i), 7'(i + 1), 7'(i + 10), 1'b1, 1'b1);
      cycle();
    end
    idle();
    repeat (4) cycle();
    chk("b2b_count", obs_pl.size(), 5);
    if (obs_pl.size() == 5 && acc_cyc.size() == 5) begin
      for (int i = 0; i < 5; i++) chk("b2b_latency", out_cyc[i] - acc_cyc[i], 2);
      chk("b2b_first_opnd1", obs_o1[0], 64'h101);
      chk("b2b_first_opnd2", obs_o2[0], 64'h10a);
      chk("b2b_last_opnd1", obs_o1[4], 64'h105);
    end

    // Stall with both stages full.
    clear_obs();
    exeReady_i = 0;
    set_pkt(96'hA, 7'd3, 7'd4, 1'b1, 1'b1); cycle();
    set_pkt(96'hB, 7'd5, 7'd6, 1'b1, 1'b1); cycle();
    set_pkt(96'hC, 7'd7, 7'd8, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("stall_in_ready", inReady_o, 1'b0);
      chk("stall_prf_addr1", prfAddr1_o, 7'd5);
      chk("stall_payload", exePayload_o, 96'hA);
      #1 cycle();
    end
    exeReady_i = 1;
    cycle();
    idle();
    repeat (4) cycle();
    chk("stall_count", obs_pl.size(), 3);
    if (obs_pl.size() == 3) begin
      chk("stall_order0", obs_pl[0], 96'hA);
      chk("stall_order1", obs_pl[1], 96'hB);
      chk("stall_order2", obs_pl[2], 96'hC);
    end

    // Bypass in the accept cycle; the PRF read returns the stale value.
    clear_obs();
    arch[9] = 64'h9;
    set_pkt(96'h90, 7'd9, 7'd0, 1'b1, 1'b0);
    bypValid_i = 4'b0100; bypTag_i = '0; bypTag_i[14 +: 7] = 7'd9; bypData_i = '0; bypData_i[128 +: 64] = 64'hDEAD;
    cycle();
    idle();
    repeat (3) cycle();
    if (obs_o1.size() == 1) begin
      chk("byp_accept_opnd1", obs_o1[0], 64'hDEAD);
      chk("byp_accept_opnd2", obs_o2[0], 64'h0);
    end else chk("byp_accept_count", obs_o1.size(), 1);

    // Bypass during an S1 hold, then a two-port collision on one tag.
    for (int pass = 0; pass < 2; pass++) begin
      clear_obs();
      exeReady_i = 0;
      set_pkt(96'h50, 7'd1, 7'd2, 1'b1, 1'b1); cycle();
      inValid_i = 0; cycle();
      set_pkt(96'h51, (pass == 0) ? 7'd5 : 7'd7, 7'd2, 1'b1, 1'b1); cycle();
      inValid_i = 0;
      for (int h = 1; h <= 3; h++) begin
        bypValid_i = '0; bypTag_i = '0; bypData_i = '0;
        if (h == 2 && pass == 0) begin
          bypValid_i = 4'b0010; bypTag_i[7 +: 7] = 7'd5; bypData_i[64 +: 64] = 64'hBEEF;
        end else if (h == 2) begin
          bypValid_i = 4'b1001; bypTag_i[0 +: 7] = 7'd7; bypTag_i[21 +: 7] = 7'd7;
          bypData_i[0 +: 64] = 64'h1111; bypData_i[192 +: 64] = 64'h3333;
        end
        cycle();
      end
      idle();
      repeat (4) cycle();
      if (obs_o1.size() == 2) chk(pass == 0 ? "byp_hold_opnd1" : "byp_prio_opnd1", obs_o1[1],
                                  pass == 0 ? 64'hBEEF : 64'h1111);
      else chk("byp_hold_count", obs_o1.size(), 2);
    end

    // Flush with both stages full and a new packet offered.
    clear_obs();
    exeReady_i = 0;
    set_pkt(96'hF0, 7'd11, 7'd12, 1'b1, 1'b1); cycle();
    set_pkt(96'hF1, 7'd13, 7'd14, 1'b1, 1'b1); cycle();
    set_pkt(96'hF2, 7'd15, 7'd16, 1'b1, 1'b1); flush_i = 1; cycle();
    idle();
    #1 chk("flush_exe_valid", exeValid_o, 1'b0);
    #1 repeat (4) cycle();
    chk("flush_no_emit", obs_pl.size(), 0);

    // Asynchronous reset in the middle of a stall.
    exeReady_i = 0;
    set_pkt(96'hE0, 7'd20, 7'd21, 1'b1, 1'b1); cycle();
    set_pkt(96'hE1, 7'd22, 7'd23, 1'b1, 1'b1); cycle();
    cycle();
    #2 reset = 1;
    #1;
    chk("arst_exe_valid", exeValid_o, 1'b0);
    chk("arst_payload", exePayload_o, 96'h0);
    chk("arst_opnd1", exeOpnd1_o, 64'h0);
    chk("arst_opnd2", exeOpnd2_o, 64'h0);
    chk("arst_in_ready", inReady_o, 1'b1);
    s1_m.delete(); s2_m.delete();
    @(negedge clk);
    reset = 0;
    idle();
    repeat (2) cycle();

    // Randomized traffic against the model.
    for (int i = 0; i < 500; i++) begin
      inValid_i   = ($urandom_range(0, 99) < 70);
      inPayload_i = {$urandom(), $urandom(), $urandom()};
      inSrc1_i    = 7'($urandom_range(0, 15));
      inSrc2_i    = 7'($urandom_range(0, 15));
      inSrc1Vld_i = ($urandom_range(0, 9) != 0);
      inSrc2Vld_i = ($urandom_range(0, 9) != 0);
      exeReady_i  = ($urandom_range(0, 99) < 60);
      flush_i     = ($urandom_range(0, 99) < 3);
      for (int k = 0; k < 4; k++) begin
        bypValid_i[k]         = ($urandom_range(0, 99) < 30);
        bypTag_i[k*7 +: 7]    = 7'($urandom_range(0, 15));
        bypData_i[k*64 +: 64] = {$urandom(), $urandom()};
      end
      cycle();
    end
    idle();
    repeat (4) cycle();
    chk("final_drained", exeValid_o, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
